// File: rtl/ysyx_25020037_ifu_pkg.sv
// ysyx_25020037_ifu_pkg: shared types and constants for the instruction fetch unit
package ysyx_25020037_ifu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_25020037_perf_cnt.sv
// ysyx_25020037_perf_cnt: 32-bit wrapping event counter
//   clk, rst_n : clock, async active-low reset
//   en_i       : count this cycle
//   cnt_o      : current count
module ysyx_25020037_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 32'd1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_25020037_ifu.sv
// ysyx_25020037_ifu: PC owner, single-outstanding icache fetch, IDU handshake, redirects, perf counters
//   redirect_valid/redirect_pc : downstream redirect (highest priority)
//   ic_addr/ic_req             : fetch request to icache (addr held until ic_ready)
//   ic_data/ic_ready/ic_hit    : icache response
//   inst_valid/inst/inst_pc/inst_ready : buffered instruction to IDU
//   perf_fetch/perf_hit/perf_miss      : event counters
module ysyx_25020037_ifu
  import ysyx_25020037_ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_req,
  input  logic [DATA_WIDTH-1:0] ic_data,
  input  logic                  ic_ready,
  input  logic                  ic_hit,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  output logic [31:0]           perf_fetch,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
);
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, ic_addr_q, inst_pc_q;
  logic [DATA_WIDTH-1:0]   inst_q;
  logic                    kill_q, kill_d, ic_req_q, inst_valid_q;
  logic                    latch, accept;
  logic [ADDR_WIDTH-1:0]   tgt;
  assign tgt    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign latch  = state_q == S_WAIT && ic_ready && !kill_q && !redirect_valid;
  // a redirect in the same cycle voids the handshake
  assign accept = state_q == S_HOLD && inst_ready && !redirect_valid;
  always_comb begin
    state_d = state_q;
    pc_d    = redirect_valid ? tgt : pc_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        kill_d  = kill_q | redirect_valid;
      end
      S_WAIT: begin
        state_d = ic_ready ? ((kill_q || redirect_valid) ? S_REQ : S_HOLD) : S_WAIT;
        kill_d  = ic_ready ? 1'b0 : (kill_q | redirect_valid);
      end
      S_HOLD: begin
        state_d = (redirect_valid || inst_ready) ? S_REQ : S_HOLD;
        pc_d    = redirect_valid ? tgt : accept ? pc_q + ADDR_WIDTH'(INST_BYTES) : pc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // ic_addr is only reloaded on entry to REQ so it stays frozen for the whole
  // icache transaction even when a redirect updates pc mid-flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      ic_req_q     <= 1'b0;
      ic_addr_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      ic_req_q     <= state_d == S_REQ;
      inst_valid_q <= state_d == S_HOLD;
      if (state_d == S_REQ) ic_addr_q <= pc_d;
      if (latch) begin
        inst_q    <= ic_data;
        inst_pc_q <= pc_q;
      end
    end
  end
  assign ic_req     = ic_req_q;
  assign ic_addr    = ic_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  ysyx_25020037_perf_cnt u_fetch (.clk(clk), .rst_n(rst_n), .en_i(accept), .cnt_o(perf_fetch));
  ysyx_25020037_perf_cnt u_hit (.clk(clk), .rst_n(rst_n), .en_i(ic_ready && ic_hit), .cnt_o(perf_hit));
  ysyx_25020037_perf_cnt u_miss (.clk(clk), .rst_n(rst_n), .en_i(ic_ready && !ic_hit), .cnt_o(perf_miss));
endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// tb_ysyx_25020037_ifu: directed self-checking bench for the instruction fetch unit
module tb_ysyx_25020037_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n, redirect_valid, ic_req, ic_ready, ic_hit, inst_valid, inst_ready;
  logic [31:0] redirect_pc, ic_addr, ic_data, inst, inst_pc, perf_fetch, perf_hit, perf_miss;
  int asserts = 0, fails = 0, cyc = 0, c0 = 0, lat = 2, cnt = 0;
  bit hit = 1'b1;
  always #5 clk = ~clk;
  ysyx_25020037_ifu dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_req(ic_req), .ic_data(ic_data), .ic_ready(ic_ready), .ic_hit(ic_hit),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .perf_fetch(perf_fetch), .perf_hit(perf_hit), .perf_miss(perf_miss)
  );
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0bad_f00d;
  endfunction
  // icache responder: ic_ready arrives lat cycles after the ic_req cycle
  initial begin : icache
    ic_ready = 1'b0; ic_data = '0; ic_hit = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      ic_ready = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin ic_ready = 1'b1; ic_data = imem(ic_addr); ic_hit = hit; end
        end
        if (ic_req) cnt = lat;
      end
    end
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    c0 = cyc;
  endtask
  task automatic wait_req(output int c);
    int n = 0;
    while (!ic_req && n < 40) begin tick(); n++; end
    if (!ic_req) begin asserts++; fails++; $display("FAIL wait_req: timeout, ic_req=%b required 1", ic_req); end
    c = cyc;
  endtask
  task automatic wait_valid(output int c);
    int n = 0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    if (!inst_valid) begin asserts++; fails++; $display("FAIL wait_valid: timeout, inst_valid=%b required 1", inst_valid); end
    c = cyc;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick(); tick();
    asserts++; if (ic_req !== 1'b0) begin fails++; $display("FAIL rst_ic_req: got %b required 0", ic_req); end
    asserts++; if (ic_addr !== RST_PC) begin fails++; $display("FAIL rst_ic_addr: got %h required %h", ic_addr, RST_PC); end
    asserts++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_inst_valid: got %b required 0", inst_valid); end
    asserts++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst: got %h required 0", inst); end
    asserts++; if (inst_pc !== RST_PC) begin fails++; $display("FAIL rst_inst_pc: got %h required %h", inst_pc, RST_PC); end
    asserts++; if ({perf_fetch, perf_hit, perf_miss} !== 96'h0) begin fails++; $display("FAIL rst_perf: got %h %h %h required 0", perf_fetch, perf_hit, perf_miss); end
  endtask
  task automatic test_hits();
    int c, v;
    do_reset(); lat = 2; hit = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(c);
      asserts++; if (c - c0 != 1 + 4 * k) begin fails++; $display("FAIL hit_req_cycle%0d: got %0d required %0d", k, c - c0, 1 + 4 * k); end
      asserts++; if (ic_addr !== RST_PC + 32'(4 * k)) begin fails++; $display("FAIL hit_addr%0d: got %h required %h", k, ic_addr, RST_PC + 32'(4 * k)); end
      wait_valid(v);
      asserts++; if (v != c + 3) begin fails++; $display("FAIL hit_valid_cycle%0d: got %0d required %0d", k, v - c, 3); end
      asserts++; if (inst_pc !== RST_PC + 32'(4 * k)) begin fails++; $display("FAIL hit_inst_pc%0d: got %h required %h", k, inst_pc, RST_PC + 32'(4 * k)); end
      asserts++; if (inst !== imem(RST_PC + 32'(4 * k))) begin fails++; $display("FAIL hit_inst%0d: got %h required %h", k, inst, imem(RST_PC + 32'(4 * k))); end
      tick();
    end
    asserts++; if (perf_fetch !== 32'd3) begin fails++; $display("FAIL hit_perf_fetch: got %0d required 3", perf_fetch); end
    asserts++; if (perf_hit !== 32'd3) begin fails++; $display("FAIL hit_perf_hit: got %0d required 3", perf_hit); end
    asserts++; if (perf_miss !== 32'd0) begin fails++; $display("FAIL hit_perf_miss: got %0d required 0", perf_miss); end
  endtask
  task automatic test_miss();
    int c, n;
    bit stable;
    do_reset(); lat = 10; hit = 1'b0; inst_ready = 1'b1;
    wait_req(c);
    stable = 1'b1; n = 0;
    while (!inst_valid && n < 30) begin
      if (ic_addr !== RST_PC) stable = 1'b0;
      tick(); n++;
    end
    asserts++; if (!stable) begin fails++; $display("FAIL miss_addr_stable: got unstable required %h", RST_PC); end
    asserts++; if (cyc != c + 11) begin fails++; $display("FAIL miss_valid_cycle: got %0d required 11", cyc - c); end
    asserts++; if (perf_miss !== 32'd1) begin fails++; $display("FAIL miss_perf_miss: got %0d required 1", perf_miss); end
    asserts++; if (perf_hit !== 32'd0) begin fails++; $display("FAIL miss_perf_hit: got %0d required 0", perf_hit); end
    asserts++; if (inst_pc !== RST_PC) begin fails++; $display("FAIL miss_inst_pc: got %h required %h", inst_pc, RST_PC); end
    lat = 2; hit = 1'b1;
  endtask
  task automatic test_hold_stall();
    int v;
    bit ok;
    logic [31:0] i0, p0;
    do_reset(); lat = 2; hit = 1'b1; inst_ready = 1'b0;
    wait_valid(v);
    i0 = inst; p0 = inst_pc; ok = 1'b1;
    repeat (5) begin
      tick();
      if (!inst_valid || inst !== i0 || inst_pc !== p0 || ic_req) ok = 1'b0;
    end
    asserts++; if (!ok) begin fails++; $display("FAIL stall_hold: got changed inst/req required stable"); end
    asserts++; if (i0 !== imem(RST_PC)) begin fails++; $display("FAIL stall_inst: got %h required %h", i0, imem(RST_PC)); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    asserts++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL stall_valid_drop: got %b required 0", inst_valid); end
    asserts++; if (ic_req !== 1'b1 || ic_addr !== RST_PC + 32'd4) begin fails++; $display("FAIL stall_next_req: got req=%b addr=%h required 1 %h", ic_req, ic_addr, RST_PC + 32'd4); end
    asserts++; if (perf_fetch !== 32'd1) begin fails++; $display("FAIL stall_perf_fetch: got %0d required 1", perf_fetch); end
  endtask
  task automatic test_redirect_wait();
    int c, v;
    do_reset(); lat = 2; hit = 1'b1; inst_ready = 1'b1;
    wait_req(c);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    asserts++; if (ic_addr !== RST_PC) begin fails++; $display("FAIL rdw_addr_held: got %h required %h", ic_addr, RST_PC); end
    tick();
    asserts++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rdw_dropped: got inst_valid=%b required 0", inst_valid); end
    asserts++; if (ic_req !== 1'b1 || ic_addr !== 32'h8000_0100) begin fails++; $display("FAIL rdw_next_req: got req=%b addr=%h required 1 80000100", ic_req, ic_addr); end
    asserts++; if (perf_hit !== 32'd1 || perf_fetch !== 32'd0) begin fails++; $display("FAIL rdw_perf: got hit=%0d fetch=%0d required 1 0", perf_hit, perf_fetch); end
    wait_valid(v);
    asserts++; if (inst_pc !== 32'h8000_0100 || inst !== imem(32'h8000_0100)) begin fails++; $display("FAIL rdw_inst: got pc=%h inst=%h required 80000100 %h", inst_pc, inst, imem(32'h8000_0100)); end
  endtask
  task automatic test_redirect_hold();
    int v;
    do_reset(); lat = 2; hit = 1'b1; inst_ready = 1'b0;
    wait_valid(v);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    asserts++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rdh_valid: got %b required 0", inst_valid); end
    asserts++; if (ic_req !== 1'b1 || ic_addr !== 32'h8000_1000) begin fails++; $display("FAIL rdh_next_req: got req=%b addr=%h required 1 80001000", ic_req, ic_addr); end
    asserts++; if (perf_fetch !== 32'd0) begin fails++; $display("FAIL rdh_perf_fetch: got %0d required 0", perf_fetch); end
  endtask
  task automatic test_reset_wait();
    int c;
    do_reset(); lat = 2; hit = 1'b1; inst_ready = 1'b1;
    wait_req(c);
    tick();
    wait_req(c);
    tick();
    rst_n = 1'b0;
    #1;
    asserts++; if (ic_req !== 1'b0 || ic_addr !== RST_PC) begin fails++; $display("FAIL rstw_ic: got req=%b addr=%h required 0 %h", ic_req, ic_addr, RST_PC); end
    asserts++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== RST_PC) begin fails++; $display("FAIL rstw_inst: got v=%b inst=%h pc=%h required 0 0 %h", inst_valid, inst, inst_pc, RST_PC); end
    asserts++; if ({perf_fetch, perf_hit, perf_miss} !== 96'h0) begin fails++; $display("FAIL rstw_perf: got %0d %0d %0d required 0", perf_fetch, perf_hit, perf_miss); end
    tick();
    rst_n = 1'b1;
    c0 = cyc;
    wait_req(c);
    asserts++; if (c != c0 + 1 || ic_addr !== RST_PC) begin fails++; $display("FAIL rstw_restart: got cycle=%0d addr=%h required 1 %h", c - c0, ic_addr, RST_PC); end
  endtask
  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_25020037_ifu.md
Name: ysyx_25020037_ifu

Overview:
Instruction fetch unit that sits directly upstream of the instruction cache in the NPC core.
- Owns the PC and issues one fetch at a time to the icache.
- Buffers the returned instruction and hands it to the IDU over a valid/ready handshake.
- Applies redirects (branch/jump/trap targets) from downstream, including squashing a fetch already in flight.
- Keeps three 32-bit performance counters.

Parameters:
- ADDR_WIDTH, 32, PC / fetch address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
- clk  in  1  single clock, all flops posedge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  redirect request from EXU/WBU, one cycle
- redirect_pc  in  ADDR_WIDTH  redirect target
- ic_addr  out  ADDR_WIDTH  fetch address to icache; held stable from ic_req until ic_ready
- ic_req  out  1  fetch request to icache, one-cycle pulse
- ic_data  in  DATA_WIDTH  instruction from icache, valid when ic_ready=1
- ic_ready  in  1  icache response strobe, one cycle
- ic_hit  in  1  icache hit flag, aligned with ic_ready
- inst_valid  out  1  buffered instruction valid to IDU
- inst  out  DATA_WIDTH  buffered instruction
- inst_pc  out  ADDR_WIDTH  PC of inst
- inst_ready  in  1  IDU accepts instruction
- perf_fetch  out  32  instructions delivered to IDU
- perf_hit  out  32  icache responses with ic_hit=1
- perf_miss  out  32  icache responses with ic_hit=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; pc = RESET_PC; kill = 0.
  - All outputs 0, except ic_addr = RESET_PC and inst_pc = RESET_PC.
  - Reset mid-transaction abandons it; no partial state survives.
- States:
  - IDLE: first cycle after reset release. Goes to REQ unconditionally.
  - REQ: drives ic_req=1 and ic_addr=pc for exactly this cycle. Goes to WAIT.
  - WAIT: ic_req=0, ic_addr held at pc. On ic_ready:
    - If kill=1: drop ic_data, clear kill, go to REQ. pc already holds the redirect target.
    - Otherwise: latch inst=ic_data and inst_pc=pc, go to HOLD.
  - HOLD: inst_valid=1.
    - On inst_ready: pc = pc+4, inst_valid drops next cycle, go to REQ.
    - Otherwise stay in HOLD; inst and inst_pc are held stable.
- Redirect (redirect_valid=1) has highest priority in every state:
  - pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; low bits are forced to zero.
  - In IDLE/HOLD: go to REQ and clear inst_valid next cycle.
  - In HOLD with inst_ready=1 in the same cycle: the handshake is void. No pc+4 and no perf_fetch increment; the IDU squashes that instruction.
  - In REQ, or in WAIT without ic_ready: set kill=1 and go to (stay in) WAIT. The icache transaction cannot be aborted.
  - In WAIT with ic_ready in the same cycle: drop the response and go to REQ.
  - ic_addr must not change while the icache is busy. During WAIT with kill=1, ic_addr stays at the old address; the new pc is used at the next REQ.
  - A second redirect while kill=1 overwrites pc; kill stays 1.
- Latency: icache hit returns ic_ready two cycles after ic_req. Hit path is REQ(t), WAIT(t+1, t+2), inst_valid at t+3. With inst_ready held high, the next REQ is at t+4, giving a hit throughput of one instruction per 4 cycles.
- pc+4 wraps modulo 2^ADDR_WIDTH.
- Counters: 32-bit, wrap at 2^32.
  - perf_hit / perf_miss increment on every ic_ready, including killed ones.
  - perf_fetch increments on each non-void inst_valid & inst_ready.

Decomposition:
- Package ysyx_25020037_ifu_pkg: state encoding (IDLE/REQ/WAIT/HOLD, 2 bits), INST_BYTES=4, default RESET_PC.
- One sub-module, ysyx_25020037_perf_cnt: a 32-bit counter with enable and async active-low reset. Instantiated three times.

Test Plan:
- Reset release, icache hits, inst_ready=1 always -> ic_req at cycles 1, 5, 9…; inst_pc 0x80000000, 0x80000004, 0x80000008; perf_fetch=3 and perf_hit=3 after the third handshake.
- Miss with ic_ready 10 cycles after ic_req, ic_hit=0 -> inst_valid one cycle after ic_ready; perf_miss=1; ic_addr stable at 0x80000000 for the whole wait.
- inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no ic_req; single handshake then pc advances by 4.
- redirect_valid with redirect_pc=0x80000103 during WAIT -> response dropped (no inst_valid); next ic_req has ic_addr=0x80000100; perf_fetch unchanged; perf_hit/perf_miss incremented.
- redirect_valid and inst_ready together in HOLD (redirect_pc=0x80001000) -> perf_fetch unchanged; next ic_req at 0x80001000; inst_valid low the following cycle.
- rst_n asserted during WAIT -> outputs immediately 0 (ic_addr=RESET_PC); after release, fetch restarts at 0x80000000; counters 0.
